// File: rtl/pace_io_map.sv
// Maps pacemaker pace outputs read from GPIO onto the heart-model side, and heart-model sense
// events back onto GPIO bits. Pace inputs are synchronised and edge-detected, sense pulses are
// stretched to a minimum width, and per-channel pace/overrun flags are sticky.
module pace_io_map #(
  parameter int GPIO_W          = 32,
  parameter int N_PACE          = 2,
  parameter int PACE_BASE       = 31,
  parameter int N_SENSE         = 2,
  parameter int SENSE_BASE      = 29,
  parameter int SYNC_STAGES     = 2,
  parameter int SENSE_PULSE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [GPIO_W-1:0]  gpio_i,
  output logic [GPIO_W-1:0]  gpio_o,
  output logic [N_PACE-1:0]  pace_level,
  output logic [N_PACE-1:0]  pace_pulse,
  input  logic [N_SENSE-1:0] sense_in,
  output logic [N_SENSE-1:0] sense_busy,
  input  logic               flag_clr,
  output logic [N_PACE-1:0]  pace_seen,
  output logic [N_SENSE-1:0] sense_ovr
);

  localparam int CNT_W    = $clog2(SENSE_PULSE_CYC + 1);
  localparam int PACE_LO  = PACE_BASE - N_PACE + 1;
  localparam int SENSE_LO = SENSE_BASE - N_SENSE + 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SENSE_PULSE_CYC);

  if (PACE_LO < 0) begin : g_bad_pace_lo
    $error("pace_io_map: pace channels extend below GPIO bit 0");
  end
  if (SENSE_LO < 0) begin : g_bad_sense_lo
    $error("pace_io_map: sense channels extend below GPIO bit 0");
  end
  if (PACE_BASE >= GPIO_W || SENSE_BASE >= GPIO_W) begin : g_bad_base
    $error("pace_io_map: channel base beyond GPIO width");
  end
  if (PACE_BASE >= SENSE_LO && SENSE_BASE >= PACE_LO) begin : g_overlap
    $error("pace_io_map: pace and sense bit ranges overlap");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pace_io_map: SYNC_STAGES must be at least 2");
  end
  if (SENSE_PULSE_CYC < 1) begin : g_bad_pulse
    $error("pace_io_map: SENSE_PULSE_CYC must be at least 1");
  end

  logic [N_PACE-1:0]  pace_raw;
  logic [N_PACE-1:0]  pace_sync_p [SYNC_STAGES];
  logic [N_PACE-1:0]  pace_hist;
  logic [CNT_W-1:0]   sense_cnt [N_SENSE];
  logic [N_SENSE-1:0] sense_rev;
  logic               unused_gpio;

  // Channel k sits at descending bit positions from its base.
  for (genvar k = 0; k < N_PACE; k++) begin : g_pace_tap
    assign pace_raw[k] = gpio_i[PACE_BASE-k];
  end

  assign unused_gpio = ^gpio_i;

  // ---- stage: pace synchroniser chain + edge history ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) pace_sync_p[s] <= '0;
      pace_hist <= '0;
    end else begin
      pace_sync_p[0] <= pace_raw;
      for (int s = 1; s < SYNC_STAGES; s++) pace_sync_p[s] <= pace_sync_p[s-1];
      pace_hist <= pace_level;
    end
  end

  assign pace_level = pace_sync_p[SYNC_STAGES-1];
  assign pace_pulse = pace_level & ~pace_hist;

  // ---- stage: sense pulse stretchers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SENSE; k++) sense_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_SENSE; k++) begin
        if (sense_in[k]) begin
          sense_cnt[k] <= LOAD;
        end else if (sense_cnt[k] != '0) begin
          sense_cnt[k] <= sense_cnt[k] - CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_SENSE; k++) begin : g_sense_busy
    assign sense_busy[k]             = (sense_cnt[k] != '0);
    assign sense_rev[N_SENSE-1-k]    = sense_busy[k];
  end

  // ---- stage: sticky flags (a set in the same cycle as flag_clr wins) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_seen <= '0;
      sense_ovr <= '0;
    end else begin
      pace_seen <= pace_pulse | (pace_seen & ~{N_PACE{flag_clr}});
      sense_ovr <= (sense_in & sense_busy) | (sense_ovr & ~{N_SENSE{flag_clr}});
    end
  end

  // Sense channel k lands on bit SENSE_BASE-k; everything else, pace bits included, stays 0.
  assign gpio_o = GPIO_W'(sense_rev) << SENSE_LO;

endmodule

// File: tb/tb_pace_io_map.sv
// Bench for pace_io_map: default instance driven from a vector table through an expected-value
// queue, plus hand sequences for reset behaviour and a 4-channel, 1-cycle-pulse instance.
module tb_pace_io_map;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [1:0]  pace_level, pace_pulse, sense_in, sense_busy, pace_seen, sense_ovr;
  logic        flag_clr;

  logic [31:0] gpio_o2;
  logic [1:0]  pace_level2, pace_pulse2, pace_seen2;
  logic [3:0]  sense_in2, sense_busy2, sense_ovr2;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  pace_io_map dut (
    .clk(clk), .rst(rst), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .pace_level(pace_level), .pace_pulse(pace_pulse),
    .sense_in(sense_in), .sense_busy(sense_busy), .flag_clr(flag_clr),
    .pace_seen(pace_seen), .sense_ovr(sense_ovr)
  );

  pace_io_map #(.N_SENSE(4), .SENSE_BASE(27), .SENSE_PULSE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .gpio_i(gpio_i), .gpio_o(gpio_o2),
    .pace_level(pace_level2), .pace_pulse(pace_pulse2),
    .sense_in(sense_in2), .sense_busy(sense_busy2), .flag_clr(flag_clr),
    .pace_seen(pace_seen2), .sense_ovr(sense_ovr2)
  );

  typedef struct {
    int         n;
    logic [1:0] pace;   // channel order: [0]=VP on bit 31, [1]=AP on bit 30
    logic [1:0] sense;
    logic       clr;
    logic [1:0] level, pulse, busy, seen, ovr;
  } vec_t;

  typedef struct {
    logic [1:0] level, pulse, busy, seen, ovr;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] exp_gpio(input logic [1:0] b);
    logic [31:0] v = '0;
    v[29] = b[0];
    v[28] = b[1];
    return v;
  endfunction

  function automatic logic [31:0] exp_gpio2(input logic [3:0] b);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++) v[27-k] = b[k];
    return v;
  endfunction

  function automatic logic [31:0] mk_g(input logic [1:0] pace);
    logic [31:0] r = $urandom;
    return {pace[0], pace[1], r[29:0]};
  endfunction

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gpio_o", gpio_o, exp_gpio(e.busy));
      chk("pace_level", 32'(pace_level), 32'(e.level));
      chk("pace_pulse", 32'(pace_pulse), 32'(e.pulse));
      chk("sense_busy", 32'(sense_busy), 32'(e.busy));
      chk("pace_seen", 32'(pace_seen), 32'(e.seen));
      chk("sense_ovr", 32'(sense_ovr), 32'(e.ovr));
    end
  endtask

  // Called on a negedge: drive inputs for the next posedge, sample at the following negedge.
  task automatic drive(input logic [31:0] g, input logic [1:0] s, input logic c, input exp_t e);
    gpio_i = g; sense_in = s; flag_clr = c;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gpio_o"}, gpio_o, 32'd0);
    chk({tag, "_level"}, 32'(pace_level), 32'd0);
    chk({tag, "_pulse"}, 32'(pace_pulse), 32'd0);
    chk({tag, "_busy"}, 32'(sense_busy), 32'd0);
    chk({tag, "_seen"}, 32'(pace_seen), 32'd0);
    chk({tag, "_ovr"}, 32'(sense_ovr), 32'd0);
  endtask

  task automatic step2(input logic [3:0] s, input logic c, input logic [3:0] busy, input logic [3:0] ovr);
    sense_in2 = s; flag_clr = c;
    @(posedge clk);
    @(negedge clk);
    chk("p4_gpio_o", gpio_o2, exp_gpio2(busy));
    chk("p4_busy", 32'(sense_busy2), 32'(busy));
    chk("p4_ovr", 32'(sense_ovr2), 32'(ovr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; gpio_i = 32'hFFFF_FFFF; sense_in = 2'b11; sense_in2 = '0; flag_clr = 1'b0;

    // pace ramp, single sense pulse, retrigger + clear, set/clear collision
    tbl.push_back('{1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{8, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{3, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10});
    tbl.push_back('{3, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10});
    tbl.push_back('{2, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{1, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00});
    tbl.push_back('{1, 2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00});
    tbl.push_back('{1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    // reset with all inputs high, then release
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    chk("in_reset_p4_gpio_o", gpio_o2, 32'd0);
    rst = 1'b0;
    #1;
    chk_zero("post_release");
    drive(32'hFFFF_FFFF, 2'b11, 1'b0, '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00});
    drive(32'hFFFF_FFFF, 2'b00, 1'b0, '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00});
    drive(32'hFFFF_FFFF, 2'b00, 1'b0, '{2'b11, 2'b00, 2'b11, 2'b11, 2'b00});
    drive(32'hFFFF_FFFF, 2'b00, 1'b1, '{2'b11, 2'b00, 2'b11, 2'b00, 2'b00});
    drive(mk_g(2'b00), 2'b00, 1'b0, '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    drive(mk_g(2'b00), 2'b00, 1'b0, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00});

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        drive(mk_g(tbl[i].pace), tbl[i].sense, tbl[i].clr,
              '{tbl[i].level, tbl[i].pulse, tbl[i].busy, tbl[i].seen, tbl[i].ovr});
      end
    end

    // reset two cycles into a sense pulse cuts it off without waiting for a clock edge
    drive(mk_g(2'b00), 2'b01, 1'b0, '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
    drive(mk_g(2'b00), 2'b00, 1'b0, '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00});
    rst = 1'b1;
    #1;
    chk("mid_reset_gpio_o", gpio_o, 32'd0);
    chk("mid_reset_busy", 32'(sense_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_mid_reset");

    // 4-channel instance with 1-cycle pulses on bits 27:24
    step2(4'b0101, 1'b0, 4'b0101, 4'b0000);
    step2(4'b0000, 1'b0, 4'b0000, 4'b0000);
    step2(4'b1010, 1'b0, 4'b1010, 4'b0000);
    step2(4'b1111, 1'b0, 4'b1111, 4'b1010);
    step2(4'b0000, 1'b0, 4'b0000, 4'b1010);
    step2(4'b0000, 1'b1, 4'b0000, 4'b0000);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pace_io_map.md
Name: pace_io_map

Overview:
- Parametrised successor to the pacemaker GPIO mapping block.
- Maps N_PACE pace outputs, driven by the pacemaker through the GPIO controller, onto the heart-model side.
- Maps N_SENSE sense events from the heart model back onto GPIO bits.
- Adds what the fixed mapping lacks:
  - input synchronisers;
  - pace rising-edge detection;
  - minimum-width stretching of sense pulses;
  - sticky per-channel pace/overrun flags.
- Sits between the AXI GPIO core and the heart-model logic.

Parameters:
- GPIO_W, 32, width of the GPIO bus.
- N_PACE, 2, number of pace channels. Channel k is read from gpio_i[PACE_BASE-k]; ch0=VP, ch1=AP.
- PACE_BASE, 31, GPIO bit of pace channel 0.
- N_SENSE, 2, number of sense channels. Channel k drives gpio_o[SENSE_BASE-k]; ch0=VS, ch1=AS.
- SENSE_BASE, 29, GPIO bit of sense channel 0.
- SYNC_STAGES, 2, synchroniser depth on pace inputs. Must be >= 2.
- SENSE_PULSE_CYC, 4, width in clk cycles of each sense pulse on GPIO. Must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- gpio_i  input  GPIO_W  GPIO pins as read back from the GPIO core.
- gpio_o  output  GPIO_W  value driven to the GPIO core.
- pace_level  output  N_PACE  synchronised pace level per channel.
- pace_pulse  output  N_PACE  one-cycle strobe on each pace rising edge.
- sense_in  input  N_SENSE  sense event request per channel, sampled each clk.
- sense_busy  output  N_SENSE  sense pulse currently being driven.
- flag_clr  input  1  clears all sticky flags.
- pace_seen  output  N_PACE  sticky: a pace rising edge has occurred.
- sense_ovr  output  N_SENSE  sticky: a sense event arrived while that channel was busy.

Behaviour:
- Reset:
  - All flops clear asynchronously on rst high: sync chains, edge history, counters, flags.
  - Every output reads 0 while rst is high and in the first cycle after release.
  - Reset mid-pulse truncates any sense pulse immediately.
- Pace path, per channel k:
  - gpio_i[PACE_BASE-k] passes through a SYNC_STAGES flop chain; the chain output is pace_level[k].
  - A change sampled at edge t appears on pace_level after SYNC_STAGES edges.
  - A history flop holds the previous pace_level.
  - pace_pulse[k] = pace_level[k] AND NOT history[k]. It is high exactly in the first cycle pace_level[k] is high.
  - A level held high produces no further pulses.
- Sense path, per channel k:
  - Each channel has a down-counter of width clog2(SENSE_PULSE_CYC+1).
  - sense_in[k] high at an edge loads SENSE_PULSE_CYC.
  - Otherwise the counter decrements while nonzero.
  - gpio_o[SENSE_BASE-k] and sense_busy[k] are registered and equal (counter != 0).
  - A single-cycle sense_in therefore yields a GPIO pulse one cycle later, exactly SENSE_PULSE_CYC cycles wide.
  - Retrigger: sense_in high while the counter is nonzero reloads SENSE_PULSE_CYC, so the pulse is extended with no gap, and sets sense_ovr[k].
  - sense_in held high keeps the output high and counts as a retrigger on every cycle after the first.
- Sticky flags:
  - pace_seen[k] sets on pace_pulse[k].
  - sense_ovr[k] sets as described under Sense path.
  - flag_clr clears all flags at the next edge.
  - A set and flag_clr in the same cycle: set wins, and the flag stays 1.
- gpio_o mapping:
  - Only sense bits are driven.
  - Pace bit positions and all unused bits are driven constant 0.
- Legality, checked with elaboration-time assertions:
  - PACE_BASE-N_PACE+1 >= 0.
  - SENSE_BASE-N_SENSE+1 >= 0.
  - PACE_BASE < GPIO_W and SENSE_BASE < GPIO_W.
  - Pace and sense bit ranges must not overlap.

Test Plan:
1. Reset: assert rst with gpio_i=32'hFFFFFFFF and sense_in=2'b11 -> gpio_o=0, pace_level=0, all flags 0. Release -> pace_level=2'b11 after 2 edges; pace_pulse=2'b11 for exactly 1 cycle; pace_seen=2'b11.
2. Pace edge: raise gpio_i[31] at edge t, drop it at t+10 -> pace_level[0] high from t+2 to t+12; pace_pulse[0] only at t+2; pace_level[1] stays 0.
3. Sense pulse: single-cycle sense_in[0] at edge t -> gpio_o[29]=1 for cycles t+1..t+4 (4 cycles); gpio_o[28]=0; sense_ovr=0.
4. Retrigger: sense_in[1] at t and at t+2 -> gpio_o[28] high t+1..t+6 with no gap; sense_ovr[1]=1. flag_clr at t+8 -> sense_ovr=0.
5. Set/clear collision: flag_clr coincident with pace_pulse[1] -> pace_seen[1] remains 1.
6. Mid-pulse reset plus params: rst at t+2 of a sense pulse -> gpio_o[29] drops to 0 asynchronously. Rerun with N_SENSE=4, SENSE_BASE=27, SENSE_PULSE_CYC=1 -> gpio_o[27:24] give 1-cycle pulses; bits 31:28 stay 0.
